pre_data_buf: RTL and testbench

//  Frame FIFO ahead of the UDP packetizer. Each entry is one frame of DATA_POINTS

---
 rtl/pre_data_buf.sv | 105 ++++++++++
 tb/tb_pre_data_buf.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pre_data_buf.sv
// Frame FIFO between the sample producer and the UDP packetizer: whole frames are written
// and read in a single cycle, with registered flags and a fill count for flow control.
module pre_data_buf #(
    parameter int N           = 8,
    parameter int DATA_POINTS = 5,
    parameter int N_SPECS     = 3
) (
    input  logic                   eth_clk,
    input  logic                   sclr_n,
    input  logic [N:0]             data_in [DATA_POINTS],
    input  logic                   wready,
    input  logic                   rready,
    output logic [N:0]             data_out [DATA_POINTS],
    output logic                   empty,
    output logic                   full,
    output logic                   wvalid,
    output logic                   rvalid,
    output logic signed [N_SPECS:0] fill_count
);

    localparam int SLOTS = 2 ** N_SPECS;
    localparam logic signed [N_SPECS:0] CNT_ZERO = (N_SPECS + 1)'(0);
    localparam logic signed [N_SPECS:0] CNT_ONE  = (N_SPECS + 1)'(1);
    localparam logic signed [N_SPECS:0] CNT_MAX  = (N_SPECS + 1)'(SLOTS - 1);
    localparam logic [N_SPECS-1:0]      PTR_ONE  = N_SPECS'(1);

    logic [N:0]              mem_q [SLOTS][DATA_POINTS];
    logic [N:0]              dout_q [DATA_POINTS];
    logic [N_SPECS-1:0]      wr_ptr_q, wr_ptr_d;
    logic [N_SPECS-1:0]      rd_ptr_q, rd_ptr_d;
    logic signed [N_SPECS:0] fill_q, fill_d;
    logic                    empty_q, empty_d;
    logic                    full_q, full_d;
    logic                    wvalid_q, rvalid_q;
    logic                    wr_en_s, rd_en_s;

    // Access qualification, pointer advance and occupancy next-state.
    // Flags are the registered ones, so a full FIFO drops a write even when a read frees a slot.
    always_comb begin
        wr_en_s  = wready & ~full_q;
        rd_en_s  = rready & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   fill_d = fill_q + CNT_ONE;
            2'b01:   fill_d = fill_q - CNT_ONE;
            default: fill_d = fill_q;
        endcase
        empty_d = (fill_d == CNT_ZERO);
        full_d  = (fill_d == CNT_MAX);
    end

    // Control state, strobes and the read-data register.
    always_ff @(posedge eth_clk or negedge sclr_n) begin
        if (!sclr_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= CNT_ZERO;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            wvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            for (int i = 0; i < DATA_POINTS; i++) begin
                dout_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            wvalid_q <= wr_en_s;
            rvalid_q <= rd_en_s;
            if (rd_en_s) begin
                dout_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // Frame storage; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge eth_clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out   = dout_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign wvalid     = wvalid_q;
    assign rvalid     = rvalid_q;
    assign fill_count = fill_q;

endmodule

// File: tb/tb_pre_data_buf.sv
// Self-checking bench for pre_data_buf: a queue of expected frames is filled as writes are
// driven and drained as reads complete; each scenario task compares DUT outputs inline.
module tb_pre_data_buf;

    localparam int N   = 8;
    localparam int DP  = 5;
    localparam int NS  = 3;
    localparam int CAP = 2 ** NS - 1;
    localparam int FW  = (N + 1) * DP;

    logic                eth_clk;
    logic                sclr_n;
    logic [N:0]          data_in [DP];
    logic                wready;
    logic                rready;
    logic [N:0]          data_out [DP];
    logic                empty;
    logic                full;
    logic                wvalid;
    logic                rvalid;
    logic signed [NS:0]  fill_count;

    int checks   = 0;
    int failures = 0;

    logic [FW-1:0] sb_q [$];
    logic [FW-1:0] exp_dout;
    logic          exp_wv;
    logic          exp_rv;

    pre_data_buf #(.N(N), .DATA_POINTS(DP), .N_SPECS(NS)) dut (
        .eth_clk    (eth_clk),
        .sclr_n     (sclr_n),
        .data_in    (data_in),
        .wready     (wready),
        .rready     (rready),
        .data_out   (data_out),
        .empty      (empty),
        .full       (full),
        .wvalid     (wvalid),
        .rvalid     (rvalid),
        .fill_count (fill_count)
    );

    initial eth_clk = 1'b0;
    always #5 eth_clk = ~eth_clk;

    function automatic logic [FW-1:0] pack(input logic [N:0] f [DP]);
        logic [FW-1:0] r;
        r = '0;
        for (int i = 0; i < DP; i++) begin
            r = {r[FW-N-2:0], f[i]};
        end
        return r;
    endfunction

    function automatic logic [FW-1:0] frame_of(input int k);
        logic [FW-1:0] r;
        r = '0;
        for (int i = 0; i < DP; i++) begin
            r = {r[FW-N-2:0], 9'((k * 37 + i * 11 + 1) % 512)};
        end
        return r;
    endfunction

    task automatic set_frame(input logic [FW-1:0] f);
        for (int i = 0; i < DP; i++) begin
            data_in[i] = f[FW-1-i*(N+1) -: (N+1)];
        end
    endtask

    // One clock edge: the model decides acceptance from its own occupancy, then updates.
    task automatic cycle();
        logic acc_w;
        logic acc_r;
        logic [FW-1:0] wf;
        acc_w = wready && (sb_q.size() < CAP);
        acc_r = rready && (sb_q.size() > 0);
        wf = pack(data_in);
        @(posedge eth_clk);
        #1;
        if (acc_r) exp_dout = sb_q.pop_front();
        if (acc_w) sb_q.push_back(wf);
        exp_wv = acc_w;
        exp_rv = acc_r;
    endtask

    task automatic test_reset();
        set_frame({9'h0c0, 9'h0ff, 9'h0ee, 9'h00f, 9'h0f0});
        wready = 1'b0;
        rready = 1'b0;
        sclr_n = 1'b0;
        repeat (2) @(posedge eth_clk);
        #3;
        sclr_n = 1'b1;
        exp_dout = '0;
        exp_wv = 1'b0;
        exp_rv = 1'b0;
        @(posedge eth_clk);
        #1;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || fill_count !== 4'sd0) begin
            failures++;
            $display("FAIL reset_flags: empty=%b full=%b fill=%0d, required 1 0 0", empty, full, fill_count);
        end
        checks++;
        if (pack(data_out) !== {FW{1'b0}} || wvalid !== 1'b0 || rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: data_out=%h wvalid=%b rvalid=%b, required 0 0 0", pack(data_out), wvalid, rvalid);
        end
    endtask

    task automatic test_read_empty();
        rready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cycle();
            checks++;
            if (rvalid !== 1'b0 || pack(data_out) !== {FW{1'b0}} || fill_count !== 4'sd0) begin
                failures++;
                $display("FAIL read_empty: rvalid=%b data_out=%h fill=%0d, required 0 0 0", rvalid, pack(data_out), fill_count);
            end
        end
        rready = 1'b0;
    endtask

    task automatic test_single();
        logic [FW-1:0] f;
        f = {9'h0c0, 9'h0ff, 9'h0ee, 9'h00f, 9'h0f0};
        set_frame(f);
        wready = 1'b1;
        cycle();
        wready = 1'b0;
        checks++;
        if (wvalid !== 1'b1 || fill_count !== 4'sd1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL single_write: wvalid=%b fill=%0d empty=%b, required 1 1 0", wvalid, fill_count, empty);
        end
        rready = 1'b1;
        cycle();
        rready = 1'b0;
        checks++;
        if (wvalid !== 1'b0) begin
            failures++;
            $display("FAIL wvalid_pulse: wvalid=%b, required 0", wvalid);
        end
        checks++;
        if (rvalid !== 1'b1 || pack(data_out) !== f || fill_count !== 4'sd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL single_read: rvalid=%b data_out=%h fill=%0d empty=%b, required 1 %h 0 1", rvalid, pack(data_out), fill_count, empty, f);
        end
        cycle();
        checks++;
        if (rvalid !== 1'b0 || pack(data_out) !== f) begin
            failures++;
            $display("FAIL dout_hold: rvalid=%b data_out=%h, required 0 %h", rvalid, pack(data_out), f);
        end
    endtask

    task automatic test_fill_wrap();
        int pulses;
        pulses = 0;
        wready = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            set_frame(frame_of(k));
            cycle();
            if (wvalid === 1'b1) pulses++;
            checks++;
            if (wvalid !== exp_wv) begin
                failures++;
                $display("FAIL fill_wvalid[%0d]: wvalid=%b, required %b", k, wvalid, exp_wv);
            end
        end
        wready = 1'b0;
        checks++;
        if (pulses != CAP || full !== 1'b1 || fill_count !== 4'sd7) begin
            failures++;
            $display("FAIL fill_full: pulses=%0d full=%b fill=%0d, required 7 1 7", pulses, full, fill_count);
        end
        rready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            cycle();
            checks++;
            if (rvalid !== 1'b1 || pack(data_out) !== exp_dout || pack(data_out) !== frame_of(k)) begin
                failures++;
                $display("FAIL drain[%0d]: rvalid=%b data_out=%h, required 1 %h", k, rvalid, pack(data_out), frame_of(k));
            end
        end
        cycle();
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || empty !== 1'b1 || pack(data_out) !== frame_of(7)) begin
            failures++;
            $display("FAIL drain_end: rvalid=%b empty=%b data_out=%h, required 0 1 %h", rvalid, empty, pack(data_out), frame_of(7));
        end
    endtask

    task automatic test_simultaneous();
        wready = 1'b1;
        for (int k = 20; k < 23; k++) begin
            set_frame(frame_of(k));
            cycle();
        end
        set_frame(frame_of(23));
        rready = 1'b1;
        cycle();
        checks++;
        if (fill_count !== 4'sd3 || wvalid !== 1'b1 || rvalid !== 1'b1 || pack(data_out) !== frame_of(20)) begin
            failures++;
            $display("FAIL rw_mid: fill=%0d wv=%b rv=%b data_out=%h, required 3 1 1 %h", fill_count, wvalid, rvalid, pack(data_out), frame_of(20));
        end
        rready = 1'b0;
        for (int k = 24; k < 28; k++) begin
            set_frame(frame_of(k));
            cycle();
        end
        checks++;
        if (full !== 1'b1 || fill_count !== 4'sd7) begin
            failures++;
            $display("FAIL rw_prefull: full=%b fill=%0d, required 1 7", full, fill_count);
        end
        set_frame(frame_of(28));
        rready = 1'b1;
        cycle();
        checks++;
        if (fill_count !== 4'sd6 || wvalid !== 1'b0 || rvalid !== 1'b1 || pack(data_out) !== frame_of(21)) begin
            failures++;
            $display("FAIL rw_full: fill=%0d wv=%b rv=%b data_out=%h, required 6 0 1 %h", fill_count, wvalid, rvalid, pack(data_out), frame_of(21));
        end
        wready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            checks++;
            if (rvalid !== exp_rv || pack(data_out) !== exp_dout) begin
                failures++;
                $display("FAIL rw_drain[%0d]: rv=%b data_out=%h, required %b %h", k, rvalid, pack(data_out), exp_rv, exp_dout);
            end
        end
        rready = 1'b0;
    endtask

    task automatic test_reset_mid();
        wready = 1'b1;
        for (int k = 40; k < 44; k++) begin
            set_frame(frame_of(k));
            cycle();
        end
        wready = 1'b0;
        #3;
        sclr_n = 1'b0;
        #1;
        sb_q.delete();
        exp_dout = '0;
        checks++;
        if (fill_count !== 4'sd0 || empty !== 1'b1 || full !== 1'b0 || pack(data_out) !== {FW{1'b0}} || wvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: fill=%0d empty=%b full=%b data_out=%h wv=%b, required 0 1 0 0 0", fill_count, empty, full, pack(data_out), wvalid);
        end
        @(posedge eth_clk);
        #3;
        sclr_n = 1'b1;
        rready = 1'b1;
        cycle();
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || pack(data_out) !== {FW{1'b0}} || fill_count !== 4'sd0) begin
            failures++;
            $display("FAIL reset_read: rv=%b data_out=%h fill=%0d, required 0 0 0", rvalid, pack(data_out), fill_count);
        end
    endtask

    initial begin
        test_reset();
        test_read_empty();
        test_single();
        test_fill_wrap();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
